// File: rtl/cdc_handshake_tx_if.sv
// Source-side bundle of the toggle-handshake crossing: valid/ready word input,
// held payload plus request toggle out, acknowledge toggle and watchdog status.
interface cdc_handshake_tx_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [DATA_W-1:0] tx_data;
  logic              req_tgl;
  logic              ack_tgl;
  logic              busy;
  logic              timeout_err;
  logic              err_clr;

  // master: the crossing source block itself
  modport master (
    input  s_valid, s_data, ack_tgl, err_clr,
    output s_ready, tx_data, req_tgl, busy, timeout_err
  );

  // slave: the environment feeding words and returning the acknowledge
  modport slave (
    output s_valid, s_data, ack_tgl, err_clr,
    input  s_ready, tx_data, req_tgl, busy, timeout_err
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// clkA end of a toggle-handshake CDC: one word per round trip, accept-to-launch 1 cycle,
// s_ready held low from accept until the synchronized ack level matches req_tgl.
module cdc_handshake_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clkA,
  input  logic                rst_n,
  cdc_handshake_tx_if.master  bus
);

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic             WD_EN   = (TIMEOUT_CYC > 0);

  state_t                  state_q;
  logic [DATA_W-1:0]       tx_data_q;
  logic                    req_tgl_q;
  logic [SYNC_STAGES-1:0]  ack_sync_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    timeout_err_q;

  logic ack_s;
  logic done_d;
  logic wd_fire_d;

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Level compare: a completed transfer is one where the returned level equals our request level.
  always_comb begin
    done_d    = (ack_s == req_tgl_q);
    wd_fire_d = WD_EN && (state_q == WAIT_ACK) && !done_d && (cnt_q == CNT_HIT);
  end

  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_tgl};
    end
  end

  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tx_data_q     <= '0;
      req_tgl_q     <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.s_valid) begin
            tx_data_q <= bus.s_data;
            req_tgl_q <= ~req_tgl_q;
            cnt_q     <= '0;
            state_q   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (done_d) begin
            state_q <= IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      // A set on the same edge as a clear must win so a fresh timeout is never lost.
      if (wd_fire_d) begin
        timeout_err_q <= 1'b1;
      end else if (bus.err_clr) begin
        timeout_err_q <= 1'b0;
      end
    end
  end

  assign bus.s_ready     = (state_q == IDLE);
  assign bus.busy        = (state_q == WAIT_ACK);
  assign bus.tx_data     = tx_data_q;
  assign bus.req_tgl     = req_tgl_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed and randomized bench for cdc_handshake_tx with a clkB toggle receiver
// and a queue-based model of the words that must arrive, in order, one per toggle.
module tb_cdc_handshake_tx;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic clkA  = 1'b0;
  logic clkB  = 1'b0;
  logic rst_n = 1'b1;

  always #5 clkA = ~clkA;
  always #7 clkB = ~clkB;

  cdc_handshake_tx_if #(.DATA_W(DW)) bus();

  cdc_handshake_tx #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clkA  (clkA),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Destination-side receiver: synchronize req, capture word on level mismatch, echo level back.
  logic          force_en  = 1'b1;
  logic          force_val = 1'b0;
  logic          rx_stall  = 1'b0;
  logic          rx_ack;
  logic [1:0]    rx_sync;
  logic [DW-1:0] rx_q[$];

  always @(posedge clkB or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b00;
      rx_ack  <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], bus.req_tgl};
      if (!rx_stall && (rx_sync[1] != rx_ack)) begin
        rx_ack <= rx_sync[1];
        rx_q.push_back(bus.tx_data);
      end
    end
  end

  assign bus.ack_tgl = force_en ? force_val : rx_ack;

  // Monitor: count request toggles and payload changes while a transfer is outstanding.
  int            toggles = 0;
  int            viol    = 0;
  logic          busy_p  = 1'b0;
  logic          req_p   = 1'b0;
  logic [DW-1:0] tx_p    = '0;

  always @(negedge clkA) begin
    if (busy_p && bus.busy && (bus.tx_data !== tx_p)) viol++;
    if (bus.req_tgl !== req_p) toggles++;
    busy_p = bus.busy;
    req_p  = bus.req_tgl;
    tx_p   = bus.tx_data;
  end

  int            n_chk  = 0;
  int            n_pass = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkA);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300 && !bus.s_ready; i++) tick();
    check("wait_ready", 32'(bus.s_ready), 32'd1);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 500 && rx_q.size() < n; i++) tick();
    check("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  // Holds s_valid with word w until an edge accepts it, then checks the launch.
  task automatic send(input logic [DW-1:0] w);
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    wait_ready();
    tick();
    exp_q.push_back(w);
    exp_req = ~exp_req;
    check("launch_busy", 32'(bus.busy), 32'd1);
    check("launch_data", 32'(bus.tx_data), 32'(w));
    check("launch_req", 32'(bus.req_tgl), 32'(exp_req));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no end, expected summary");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.err_clr = 1'b0;

    // Reset and idle
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(bus.s_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req", 32'(bus.req_tgl), 32'd0);
    check("rst_txdata", 32'(bus.tx_data), 32'd0);
    check("rst_err", 32'(bus.timeout_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus.s_ready), 32'd1);

    // Stray ack level while idle is ignored
    force_val = 1'b1;
    repeat (5) tick();
    check("stray_ack_ready", 32'(bus.s_ready), 32'd1);
    check("stray_ack_req", 32'(bus.req_tgl), 32'd0);
    check("stray_ack_err", 32'(bus.timeout_err), 32'd0);
    force_val = 1'b0;
    repeat (4) tick();

    // Single transfer with hand-timed ack: ack changes between accept edge N and N+1
    send(8'hA5);
    bus.s_valid = 1'b0;
    check("single_ready_low", 32'(bus.s_ready), 32'd0);
    force_val = 1'b1;
    for (int k = 0; k < SS; k++) begin
      tick();
      check("ack_latency_busy", 32'(bus.s_ready), 32'd0);
    end
    tick();
    check("ack_latency_ready", 32'(bus.s_ready), 32'd1);

    // Hand the ack over to the receiver once it has echoed the same level
    repeat (10) tick();
    force_en = 1'b0;
    tick();
    check("handover_ready", 32'(bus.s_ready), 32'd1);
    rx_q.delete();
    exp_q.delete();

    // Back-pressure: valid held continuously for 01,02,03
    base = toggles;
    send(8'h01);
    send(8'h02);
    send(8'h03);

    // Random words with random gaps
    for (int i = 0; i < 20; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      bus.s_valid = 1'b0;
      repeat (gap) tick();
      send(8'($urandom));
    end
    bus.s_valid = 1'b0;
    wait_ready();
    n = exp_q.size();
    wait_rx(n);
    for (int i = 0; i < n && i < rx_q.size(); i++) check("order", 32'(rx_q[i]), 32'(exp_q[i]));
    tick();
    check("toggle_count", 32'(toggles - base), 32'(n));
    check("data_stable", 32'(viol), 32'd0);
    check("final_req", 32'(bus.req_tgl), 32'(exp_req));
    check("no_timeout", 32'(bus.timeout_err), 32'd0);

    // Watchdog: no ack; flag rises TO cycles after accept, transfer not aborted
    rx_stall = 1'b1;
    send(8'h5A);
    bus.s_valid = 1'b0;
    for (int k = 1; k < TO; k++) begin
      tick();
      check("wd_early", 32'(bus.timeout_err), 32'd0);
    end
    tick();
    check("wd_set", 32'(bus.timeout_err), 32'd1);
    check("wd_still_busy", 32'(bus.busy), 32'd1);
    repeat (5) tick();
    check("wd_holds_wait", 32'(bus.busy), 32'd1);
    rx_stall = 1'b0;
    wait_ready();
    check("wd_sticky", 32'(bus.timeout_err), 32'd1);
    repeat (3) tick();
    check("wd_sticky_idle", 32'(bus.timeout_err), 32'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("wd_clear", 32'(bus.timeout_err), 32'd0);

    // Set and clear on the same edge: set wins
    rx_stall = 1'b1;
    send(8'hC3);
    bus.s_valid = 1'b0;
    repeat (TO - 1) tick();
    check("wd_pre_race", 32'(bus.timeout_err), 32'd0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("wd_set_wins", 32'(bus.timeout_err), 32'd1);
    rx_stall = 1'b0;
    wait_ready();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("wd_clear2", 32'(bus.timeout_err), 32'd0);

    // Reset mid-transfer, then a normal transfer
    repeat (10) tick();
    send(8'h3C);
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(bus.req_tgl), 32'd0);
    check("midrst_txdata", 32'(bus.tx_data), 32'd0);
    check("midrst_ready", 32'(bus.s_ready), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_req = 1'b0;
    tick();
    rx_q.delete();
    send(8'h77);
    bus.s_valid = 1'b0;
    wait_ready();
    wait_rx(1);
    if (rx_q.size() > 0) check("post_rst_word", 32'(rx_q[0]), 32'h77);
    check("post_rst_req", 32'(bus.req_tgl), 32'd1);
    check("post_rst_err", 32'(bus.timeout_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
